// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults and flattened-port slicing helper for the register file.
`default_nettype none

package rf_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 4;
  localparam int DEF_NUM_WR = 2;
  localparam int ZERO_ADDR  = 0;

  // Bit offset of element `port` inside a flattened vector of `width`-bit elements.
  function automatic int lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits, set-over-clear priority, per-read-port lookup.
`default_nettype none

module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int NUM_WR   = DEF_NUM_WR,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR-1:0]        set_busy,
  input  logic [NUM_WR*ADDR_W-1:0] set_addr,
  output logic [NUM_RD-1:0]        busy_lookup
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] set_hit;
  logic [DEPTH-1:0] clr_hit;

  always_comb begin
    set_hit = '0;
    clr_hit = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (set_busy[j]) set_hit[set_addr[lsb(j, ADDR_W) +: ADDR_W]] = 1'b1;
      if (we[j])       clr_hit[wr_addr[lsb(j, ADDR_W) +: ADDR_W]]  = 1'b1;
    end
    if (ZERO_REG != 0) set_hit[ZERO_ADDR] = 1'b0;
  end

  // A new producer issued in the same cycle as the old one retires keeps the register busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= (busy & ~clr_hit) | set_hit;
  end

  always_comb begin
    busy_lookup = '0;
    for (int k = 0; k < NUM_RD; k++)
      busy_lookup[k] = busy[rd_addr[lsb(k, ADDR_W) +: ADDR_W]];
  end

endmodule

`default_nettype wire

// File: rtl/multiport_register_file.sv
// multiport_register_file: N-read / M-write register file with bypass, zero register and busy scoreboard.
`default_nettype none

module multiport_register_file
  import rf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int NUM_WR   = DEF_NUM_WR,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_WR-1:0]        set_busy,
  input  logic [NUM_WR*ADDR_W-1:0] set_addr,
  output logic                     wr_conflict
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_ADDR);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [NUM_RD-1:0] sb_busy;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == ZADDR);
  endfunction

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .we          (we),
    .wr_addr     (wr_addr),
    .set_busy    (set_busy),
    .set_addr    (set_addr),
    .busy_lookup (sb_busy)
  );

  // Ascending port order: the last non-blocking assignment (highest index, youngest) wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (we[j] && !is_zero_reg(wr_addr[lsb(j, ADDR_W) +: ADDR_W]))
          regs[wr_addr[lsb(j, ADDR_W) +: ADDR_W]] <= wr_data[lsb(j, DATA_W) +: DATA_W];
      end
    end
  end

  always_comb begin
    wr_conflict = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (we[i] && we[j]
            && (wr_addr[lsb(i, ADDR_W) +: ADDR_W] == wr_addr[lsb(j, ADDR_W) +: ADDR_W])
            && (wr_addr[lsb(i, ADDR_W) +: ADDR_W] != ZADDR))
          wr_conflict = 1'b1;
      end
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] fwd_data;
    logic              fwd;
    logic              set_match;
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      a         = rd_addr[lsb(k, ADDR_W) +: ADDR_W];
      fwd_data  = '0;
      fwd       = 1'b0;
      set_match = 1'b0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (we[j] && (wr_addr[lsb(j, ADDR_W) +: ADDR_W] == a) && (a != ZADDR)) begin
          fwd_data = wr_data[lsb(j, DATA_W) +: DATA_W];
          fwd      = 1'b1;
        end
        if (set_busy[j] && (set_addr[lsb(j, ADDR_W) +: ADDR_W] == a)) set_match = 1'b1;
      end
      if (is_zero_reg(a)) begin
        rd_data[lsb(k, DATA_W) +: DATA_W] = '0;
        rd_busy[k]                        = 1'b0;
      end else if ((BYPASS != 0) && fwd) begin
        rd_data[lsb(k, DATA_W) +: DATA_W] = fwd_data;
        rd_busy[k]                        = sb_busy[k] & set_match;
      end else begin
        rd_data[lsb(k, DATA_W) +: DATA_W] = regs[a];
        rd_busy[k]                        = sb_busy[k];
      end
    end
  end

endmodule

`default_nettype wire
